// File: rtl/lap_controller.sv
// Lap/split sequencer: captures lap times into a circular buffer and selects
// what the display chain shows (live time, a freshly frozen lap, or stored
// laps paged through while the timer is paused).
module lap_controller #(
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 100000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       lap,
   input  logic       clear,
   input  logic       run,
   input  logic [5:0] hour,
   input  logic [5:0] minute,
   input  logic [5:0] second,
   input  logic [6:0] m_sec,
   output logic [5:0] disp_hour,
   output logic [5:0] disp_minute,
   output logic [5:0] disp_second,
   output logic [6:0] disp_m_sec,
   output logic       showing_lap,
   output logic [4:0] lap_index,
   output logic [4:0] lap_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [4:0]    FULL      = 5'(DEPTH);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {S_LIVE, S_HOLD, S_REVIEW} state_t;

   state_t          r_state, w_nxt_state;
   logic            r_lap_q, r_clear_q;
   logic [24:0]     r_disp, w_nxt_disp;
   logic            r_showing;
   logic [4:0]      r_lap_index, w_nxt_index;
   logic [4:0]      r_lap_count, w_nxt_count;
   logic [AW-1:0]   r_wr_ptr, w_nxt_wr;
   logic [AW-1:0]   r_rd_ptr, w_nxt_rd;
   logic [HW-1:0]   r_hold_cnt, w_nxt_hold;
   logic [24:0]     r_buf [DEPTH];

   logic            w_lap_rise, w_clear_rise, w_cap;
   logic [24:0]     w_live;
   logic [4:0]      w_cnt_inc;
   logic [AW-1:0]   w_oldest;

   assign w_lap_rise   = lap & ~r_lap_q;
   assign w_clear_rise = clear & ~r_clear_q;
   assign w_live       = {hour, minute, second, m_sec};
   assign w_cnt_inc    = (r_lap_count == FULL) ? r_lap_count : r_lap_count + 5'd1;
   // A full buffer truncates to 0 here, so the oldest entry is wr_ptr itself.
   assign w_oldest     = r_wr_ptr - AW'(r_lap_count);

   // Next-state, pointer/counter update and display source selection.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_wr    = r_wr_ptr;
      w_nxt_rd    = r_rd_ptr;
      w_nxt_count = r_lap_count;
      w_nxt_index = r_lap_index;
      w_nxt_hold  = r_hold_cnt;
      w_cap       = 1'b0;
      w_nxt_disp  = r_disp;
      case (r_state)
         S_LIVE: begin
            // Clear beats lap when paused; capture only while running.
            if (w_clear_rise && !run) begin
               w_nxt_count = '0;
               w_nxt_wr    = '0;
            end else if (w_lap_rise && run) begin
               w_cap = 1'b1;
            end else if (w_lap_rise && r_lap_count != 5'd0) begin
               w_nxt_state = S_REVIEW;
               w_nxt_rd    = w_oldest;
               w_nxt_index = 5'd1;
            end
         end
         S_HOLD: begin
            if (w_lap_rise && run)             w_cap = 1'b1;
            else if (r_hold_cnt == HOLD_LAST)  w_nxt_state = S_LIVE;
            else                               w_nxt_hold = r_hold_cnt + HW'(1);
         end
         S_REVIEW: begin
            if (run) begin
               w_nxt_state = S_LIVE;
            end else if (w_lap_rise) begin
               if (r_lap_index < r_lap_count) begin
                  w_nxt_rd    = r_rd_ptr + AW'(1);
                  w_nxt_index = r_lap_index + 5'd1;
               end else begin
                  w_nxt_state = S_LIVE;
               end
            end else if (w_clear_rise) begin
               w_nxt_count = '0;
               w_nxt_wr    = '0;
               w_nxt_state = S_LIVE;
            end
         end
         default: w_nxt_state = S_LIVE;
      endcase
      if (w_cap) begin
         w_nxt_state = S_HOLD;
         w_nxt_hold  = '0;
         w_nxt_wr    = r_wr_ptr + AW'(1);
         w_nxt_count = w_cnt_inc;
         w_nxt_index = w_cnt_inc;
      end
      if (w_nxt_state == S_LIVE) w_nxt_index = '0;
      case (w_nxt_state)
         S_LIVE:   w_nxt_disp = w_live;
         S_HOLD:   w_nxt_disp = w_cap ? w_live : r_disp;
         S_REVIEW: w_nxt_disp = r_buf[w_nxt_rd];
         default:  w_nxt_disp = w_live;
      endcase
   end

   // State and datapath registers; edge-detect history resets high so a
   // button held through reset does not fire.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_LIVE;
         r_lap_q     <= 1'b1;
         r_clear_q   <= 1'b1;
         r_disp      <= '0;
         r_showing   <= 1'b0;
         r_lap_index <= '0;
         r_lap_count <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_hold_cnt  <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_lap_q     <= lap;
         r_clear_q   <= clear;
         r_disp      <= w_nxt_disp;
         r_showing   <= (w_nxt_state != S_LIVE);
         r_lap_index <= w_nxt_index;
         r_lap_count <= w_nxt_count;
         r_wr_ptr    <= w_nxt_wr;
         r_rd_ptr    <= w_nxt_rd;
         r_hold_cnt  <= w_nxt_hold;
      end
   end

   // Lap storage; contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (w_cap && !reset) r_buf[r_wr_ptr] <= w_live;
   end

   assign {disp_hour, disp_minute, disp_second, disp_m_sec} = r_disp;
   assign showing_lap = r_showing;
   assign lap_index   = r_lap_index;
   assign lap_count   = r_lap_count;

endmodule
